// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw switch inputs in, debounced level and event pulses out.
interface button_conditioner_if #(
  parameter int NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0] i_Switch;
  logic [NUM_BUTTONS-1:0] o_Level;
  logic [NUM_BUTTONS-1:0] o_Press;
  logic [NUM_BUTTONS-1:0] o_Release;
  logic [NUM_BUTTONS-1:0] o_Long;
  logic [NUM_BUTTONS-1:0] o_Repeat;

  // Driver side: owns the switches, observes the conditioned outputs.
  modport master (
    output i_Switch,
    input  o_Level,
    input  o_Press,
    input  o_Release,
    input  o_Long,
    input  o_Repeat
  );

  // Conditioner side: consumes the switches, produces levels and pulses.
  modport slave (
    input  i_Switch,
    output o_Level,
    output o_Press,
    output o_Release,
    output o_Long,
    output o_Repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Button conditioner: per-channel synchronizer, debouncer and press/long/repeat
// event generator. Feeds debounced levels and one-cycle event pulses to the
// stopwatch. Every channel owns its own counters.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_TIME   = 250_000,
  parameter int LONG_PRESS_TIME = 25_000_000,
  parameter int REPEAT_TIME     = 5_000_000
) (
  input logic                  i_Clk,
  input logic                  i_Rst_L,
  button_conditioner_if.slave  io_Bus
);

  // The debounce counter tops out at DEBOUNCE_TIME-1, the hold timer at
  // LONG_PRESS_TIME-1 or REPEAT_TIME-1, so $clog2 of each limit is enough.
  localparam int DB_W      = $clog2(DEBOUNCE_TIME);
  localparam int TIMER_MAX = (LONG_PRESS_TIME > REPEAT_TIME) ? LONG_PRESS_TIME : REPEAT_TIME;
  localparam int TM_W      = $clog2(TIMER_MAX);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic [1:0]             r_rstSync;
  logic                   w_rstN;

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;

  logic [DB_W-1:0]        r_dbCnt     [NUM_BUTTONS];
  logic [DB_W-1:0]        w_dbCntNext [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_differ;
  logic [NUM_BUTTONS-1:0] w_accept;
  logic [NUM_BUTTONS-1:0] r_level;

  state_t                 r_state     [NUM_BUTTONS];
  state_t                 w_stateNext [NUM_BUTTONS];
  logic [TM_W-1:0]        r_timer     [NUM_BUTTONS];
  logic [TM_W-1:0]        w_timerNext [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] w_pressNext;
  logic [NUM_BUTTONS-1:0] w_releaseNext;
  logic [NUM_BUTTONS-1:0] w_longNext;
  logic [NUM_BUTTONS-1:0] w_repeatNext;
  logic [NUM_BUTTONS-1:0] r_press;
  logic [NUM_BUTTONS-1:0] r_release;
  logic [NUM_BUTTONS-1:0] r_long;
  logic [NUM_BUTTONS-1:0] r_repeat;

  // Reset synchronizer: asserts immediately, releases two clock edges later.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rstSync <= '0;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  // Two-flop synchronizer for every raw switch before any other use.
  always_ff @(posedge i_Clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_Bus.i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce decision: count disagreeing cycles, accept on the DEBOUNCE_TIME-th,
  // and clear the count on agreement or acceptance so it can never wrap.
  always_comb begin
    w_differ = '0;
    w_accept = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_dbCntNext[i] = '0;
      w_differ[i]    = r_sync2[i] ^ r_level[i];
      w_accept[i]    = w_differ[i] && (r_dbCnt[i] == DB_W'(DEBOUNCE_TIME - 1));
      if (w_differ[i] && !w_accept[i]) begin
        w_dbCntNext[i] = r_dbCnt[i] + DB_W'(1);
      end
    end
  end

  // Debounce counters and accepted levels.
  always_ff @(posedge i_Clk or negedge w_rstN) begin
    if (!w_rstN) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_dbCnt[i] <= '0;
      end
      r_level <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_dbCnt[i] <= w_dbCntNext[i];
      end
      r_level <= r_level ^ w_accept;
    end
  end

  // Event FSM next state: an accepted fall always beats a long/repeat threshold
  // landing on the same cycle.
  always_comb begin
    w_pressNext   = '0;
    w_releaseNext = '0;
    w_longNext    = '0;
    w_repeatNext  = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_stateNext[i] = r_state[i];
      w_timerNext[i] = '0;
      case (r_state[i])
        ST_RELEASED: begin
          if (w_accept[i] && r_sync2[i]) begin
            w_stateNext[i] = ST_PRESSED;
            w_pressNext[i] = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (w_accept[i] && !r_sync2[i]) begin
            w_stateNext[i]   = ST_RELEASED;
            w_releaseNext[i] = 1'b1;
          end else if (r_timer[i] == TM_W'(LONG_PRESS_TIME - 1)) begin
            w_stateNext[i] = ST_HELD;
            w_longNext[i]  = 1'b1;
          end else begin
            w_timerNext[i] = r_timer[i] + TM_W'(1);
          end
        end
        ST_HELD: begin
          if (w_accept[i] && !r_sync2[i]) begin
            w_stateNext[i]   = ST_RELEASED;
            w_releaseNext[i] = 1'b1;
          end else if (r_timer[i] == TM_W'(REPEAT_TIME - 1)) begin
            w_repeatNext[i] = 1'b1;
          end else begin
            w_timerNext[i] = r_timer[i] + TM_W'(1);
          end
        end
        default: begin
          w_stateNext[i] = ST_RELEASED;
        end
      endcase
    end
  end

  // Event FSM state, hold timers and registered event pulses.
  always_ff @(posedge i_Clk or negedge w_rstN) begin
    if (!w_rstN) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_state[i] <= ST_RELEASED;
        r_timer[i] <= '0;
      end
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_repeat  <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_state[i] <= w_stateNext[i];
        r_timer[i] <= w_timerNext[i];
      end
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
      r_long    <= w_longNext;
      r_repeat  <= w_repeatNext;
    end
  end

  assign io_Bus.o_Level   = r_level;
  assign io_Bus.o_Press   = r_press;
  assign io_Bus.o_Release = r_release;
  assign io_Bus.o_Long    = r_long;
  assign io_Bus.o_Repeat  = r_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. A sliding-window/timestamp model
// predicts every output each cycle; directed steps cover the clean press,
// bounce, long/short hold, reset and simultaneous-press cases, then random
// switch activity runs against the same model.
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rstL;

  button_conditioner_if #(.NUM_BUTTONS(NB)) btnIf ();

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_TIME  (DB),
    .LONG_PRESS_TIME(LP),
    .REPEAT_TIME    (RP)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rstL),
    .io_Bus (btnIf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: recent effective samples (index 0 = this edge),
  // expected outputs, press timestamps and edges seen since reset release.
  logic [NB-1:0] sampQ[$];
  logic [NB-1:0] mLevel, mPress, mRelease, mLong, mRepeat;
  int            pressEdge [NB];
  int            edgeNum  = 0;
  int            relCount = 0;

  task automatic modelReset();
    sampQ.delete();
    for (int j = 0; j < DB + 2; j++) sampQ.push_front('0);
    mLevel   = '0;
    mPress   = '0;
    mRelease = '0;
    mLong    = '0;
    mRepeat  = '0;
    relCount = 0;
  endtask

  // One clock edge of the model. A level is accepted when the DB samples that
  // reached the comparator (taken 2..DB+1 edges ago) all disagree with it.
  // Events are timed from the press edge with plain arithmetic.
  task automatic modelEdge(input logic rstNow, input logic [NB-1:0] sw);
    logic [NB-1:0] s;
    logic [NB-1:0] old;
    bit            allDiff;
    int            held;
    edgeNum++;
    mPress   = '0;
    mRelease = '0;
    mLong    = '0;
    mRepeat  = '0;
    if (!rstNow) begin
      modelReset();
      return;
    end
    if (relCount < 3) relCount++;
    s = (relCount >= 3) ? sw : '0;
    sampQ.push_front(s);
    void'(sampQ.pop_back());
    if (relCount < 3) return;
    for (int c = 0; c < NB; c++) begin
      allDiff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        old = sampQ[j];
        if (old[c] == mLevel[c]) allDiff = 1'b0;
      end
      if (allDiff) begin
        mLevel[c] = ~mLevel[c];
        if (mLevel[c]) begin
          mPress[c]    = 1'b1;
          pressEdge[c] = edgeNum;
        end else begin
          mRelease[c] = 1'b1;
        end
      end else if (mLevel[c]) begin
        held = edgeNum - pressEdge[c];
        if (held == LP) mLong[c] = 1'b1;
        else if (held > LP && ((held - LP) % RP) == 0) mRepeat[c] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (btnIf.o_Level === mLevel) else begin
      bad++;
      $error("[TB] FAIL %s o_Level got=%b exp=%b", tag, btnIf.o_Level, mLevel);
    end
    total++;
    assert (btnIf.o_Press === mPress) else begin
      bad++;
      $error("[TB] FAIL %s o_Press got=%b exp=%b", tag, btnIf.o_Press, mPress);
    end
    total++;
    assert (btnIf.o_Release === mRelease) else begin
      bad++;
      $error("[TB] FAIL %s o_Release got=%b exp=%b", tag, btnIf.o_Release, mRelease);
    end
    total++;
    assert (btnIf.o_Long === mLong) else begin
      bad++;
      $error("[TB] FAIL %s o_Long got=%b exp=%b", tag, btnIf.o_Long, mLong);
    end
    total++;
    assert (btnIf.o_Repeat === mRepeat) else begin
      bad++;
      $error("[TB] FAIL %s o_Repeat got=%b exp=%b", tag, btnIf.o_Repeat, mRepeat);
    end
  endtask

  // Drive the switches for a number of edges, checking every cycle #1 after the edge.
  task automatic applyStimulus(input logic [NB-1:0] sw, input int cycles, input string tag);
    for (int n = 0; n < cycles; n++) begin
      btnIf.i_Switch = sw;
      @(posedge clk);
      modelEdge(rstL, btnIf.i_Switch);
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic directCheck(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  logic [NB-1:0] rnd;
  int            left [NB];

  initial begin
    rstL           = 1'b0;
    btnIf.i_Switch = '0;
    modelReset();

    $display("[TB] reset phase");
    applyStimulus('0, 4, "reset");
    directCheck("reset_level", btnIf.o_Level, 4'b0000);
    rstL = 1'b1;
    applyStimulus('0, 10, "idle");

    $display("[TB] clean press on channel 0");
    applyStimulus(4'b0001, 5, "clean_press");
    directCheck("clean_press_early", btnIf.o_Press, 4'b0000);
    applyStimulus(4'b0001, 1, "clean_press");
    directCheck("clean_press_edge", btnIf.o_Press, 4'b0001);
    directCheck("clean_press_level", btnIf.o_Level, 4'b0001);
    applyStimulus(4'b0001, 4, "clean_hold");
    applyStimulus(4'b0000, 6, "clean_release");
    directCheck("clean_release_edge", btnIf.o_Release, 4'b0001);
    applyStimulus(4'b0000, 5, "idle");

    $display("[TB] bounce on channel 1");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0010, 2, "bounce");
      applyStimulus(4'b0000, 2, "bounce");
    end
    applyStimulus(4'b0010, 12, "bounce_settle");
    applyStimulus(4'b0000, 10, "bounce_release");

    $display("[TB] long hold on channel 2");
    applyStimulus(4'b0100, 6, "long_press");
    directCheck("long_press_edge", btnIf.o_Press, 4'b0100);
    applyStimulus(4'b0100, LP, "long_wait");
    directCheck("long_edge", btnIf.o_Long, 4'b0100);
    applyStimulus(4'b0100, RP, "repeat_wait");
    directCheck("repeat_edge", btnIf.o_Repeat, 4'b0100);
    applyStimulus(4'b0100, 15, "held");
    applyStimulus(4'b0000, 10, "long_release");

    $display("[TB] short hold and release-wins tie on channel 0");
    applyStimulus(4'b0001, 19, "short_hold");
    applyStimulus(4'b0000, 30, "short_release");
    applyStimulus(4'b0001, 20, "tie_hold");
    applyStimulus(4'b0000, 30, "tie_release");

    $display("[TB] reset mid-press");
    applyStimulus(4'b0001, 15, "pre_reset");
    rstL = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    directCheck("async_reset_level", btnIf.o_Level, 4'b0000);
    applyStimulus(4'b0001, 3, "in_reset");
    rstL = 1'b1;
    applyStimulus(4'b0001, 12, "post_reset");
    applyStimulus(4'b0000, 10, "post_reset_release");

    $display("[TB] simultaneous press on channels 0 and 3");
    applyStimulus(4'b1001, 6, "dual_press");
    directCheck("dual_press_edge", btnIf.o_Press, 4'b1001);
    applyStimulus(4'b1001, 4, "dual_hold");
    applyStimulus(4'b0000, 10, "dual_release");

    $display("[TB] random activity");
    rnd = '0;
    for (int c = 0; c < NB; c++) left[c] = $urandom_range(1, 10);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (left[c] == 0) begin
          rnd[c]  = ~rnd[c];
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end
        left[c]--;
      end
      if (cyc == 700) begin
        rstL = 1'b0;
        modelReset();
        #1;
        checkOutput("random_reset");
        applyStimulus(rnd, 2, "random_in_reset");
        rstL = 1'b1;
      end
      applyStimulus(rnd, 1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL be the upstream input stage that feeds debounced levels and event pulses to the stopwatch.
REQ-002 Parameter NUM_BUTTONS, default 4: number of independent channels.
REQ-003 Parameter DEBOUNCE_TIME, default 250_000: consecutive cycles of disagreement required to accept a new level (10 ms at 25 MHz); legal range is 2 or more.
REQ-004 Parameter LONG_PRESS_TIME, default 25_000_000: cycles from press to long-press event (1 s); it SHALL be greater than 1.
REQ-005 Parameter REPEAT_TIME, default 5_000_000: auto-repeat period while held after a long press (200 ms); it SHALL be greater than 1.
REQ-006 i_Clk  input  1  system clock (25 MHz).
REQ-007 i_Rst_L  input  1  asynchronous active-low reset.
REQ-008 i_Switch  input  NUM_BUTTONS  raw, asynchronous, bouncing switches; active high.
REQ-009 o_Level  output  NUM_BUTTONS  debounced level per channel.
REQ-010 o_Press  output  NUM_BUTTONS  one-cycle pulse on each accepted press.
REQ-011 o_Release  output  NUM_BUTTONS  one-cycle pulse on each accepted release.
REQ-012 o_Long  output  NUM_BUTTONS  one-cycle pulse, at most once per press.
REQ-013 o_Repeat  output  NUM_BUTTONS  one-cycle periodic pulse while held after o_Long.

Function
REQ-014 Each channel SHALL be fully independent; channels SHALL share no counters.
REQ-015 Each i_Switch bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Debounce counter behaviour: increment each cycle the synchronized value differs from the accepted level; clear to 0 on any cycle they agree.
REQ-017 Debounce acceptance: the accepted level SHALL update on the edge where the counter equals DEBOUNCE_TIME-1 and the values still differ; the counter clears on that same edge.
REQ-018 A clean input transition SHALL appear on o_Level exactly DEBOUNCE_TIME+1 clock edges after the first edge that samples the new value.
REQ-019 The counter SHALL be sized by $clog2 of its limit and SHALL never wrap.
REQ-020 Per-channel FSM state RELEASED: on accepted rise, go to PRESSED and assert o_Press.
REQ-021 Per-channel FSM state PRESSED: on accepted fall, go to RELEASED and assert o_Release; otherwise count hold cycles.
REQ-022 PRESSED to HELD: when the hold count reaches LONG_PRESS_TIME-1, go to HELD and assert o_Long, exactly LONG_PRESS_TIME cycles after o_Press.
REQ-023 Per-channel FSM state HELD: assert o_Repeat every REPEAT_TIME cycles, the first pulse REPEAT_TIME cycles after o_Long; on accepted fall, go to RELEASED and assert o_Release.
REQ-024 All outputs SHALL be registered; o_Press and o_Release SHALL coincide with the first cycle o_Level shows the new value.
REQ-025 Simultaneous events: an accepted fall on the same cycle as a long or repeat threshold SHALL win; assert o_Release only; no o_Long or o_Repeat.
REQ-026 o_Repeat SHALL continue indefinitely while held; its counter SHALL restart from 0 on every pulse.
REQ-027 Pulses narrower than DEBOUNCE_TIME cycles SHALL produce no output activity.

Reset
REQ-028 While i_Rst_L is 0, all synchronizers, counters and outputs SHALL be 0 and every FSM SHALL be in RELEASED, asynchronously.
REQ-029 Reset mid-press SHALL drop all outputs immediately without an o_Release pulse.
REQ-030 A switch held high across reset release SHALL be treated as a new press: o_Press after DEBOUNCE_TIME+1 cycles.
REQ-031 Reset deassertion SHALL be synchronized to i_Clk before use.

Verification (DEBOUNCE_TIME=4, LONG_PRESS_TIME=20, REPEAT_TIME=5)
REQ-032 Clean press: i_Switch[0] goes 0->1 at edge N and is held 10 cycles -> o_Level[0]=1 and a single o_Press[0] at edge N+5; on release 0, o_Release[0] 5 edges later.
REQ-033 Bounce: toggle i_Switch[1] every 2 cycles for 12 cycles, then hold 1 -> no pulses during bouncing; exactly one o_Press[1] 5 edges after the final rise.
REQ-034 Long hold: hold 40 cycles past o_Press at edge P -> o_Long at P+20; o_Repeat at P+25, P+30, P+35; one o_Release after release.
REQ-035 Short hold: release accepted at P+19 -> o_Release at P+19; o_Long never asserted.
REQ-036 Reset at P+10 with switch held -> all outputs 0 immediately; after i_Rst_L returns to 1, o_Press again 5 cycles after the first sample.
REQ-037 Channels 0 and 3 pressed on the same edge -> o_Press=4'b1001 in one cycle; channels 1 and 2 stay 0.
